// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative radix-2 mult/div and HI/LO.
// Ports: clk, rst_n (async, active low), flush | in_valid/in_ready,
//   alu_code, a, b | out_valid, result, overflow, hi, lo, busy.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_AND   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_NOR   = 5'd4;
    localparam logic [4:0] OP_SUB   = 5'd5;
    localparam logic [4:0] OP_ANDI  = 5'd6;
    localparam logic [4:0] OP_XORI  = 5'd7;
    localparam logic [4:0] OP_ORI   = 5'd8;
    localparam logic [4:0] OP_JR    = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BGEZ  = 5'd12;
    localparam logic [4:0] OP_BGTZ  = 5'd13;
    localparam logic [4:0] OP_BLEZ  = 5'd14;
    localparam logic [4:0] OP_BLTZ  = 5'd15;
    localparam logic [4:0] OP_SLL   = 5'd16;
    localparam logic [4:0] OP_SRL   = 5'd17;
    localparam logic [4:0] OP_SRA   = 5'd18;
    localparam logic [4:0] OP_SLT   = 5'd19;
    localparam logic [4:0] OP_SLTU  = 5'd20;
    localparam logic [4:0] OP_MULT  = 5'd21;
    localparam logic [4:0] OP_MULTU = 5'd22;
    localparam logic [4:0] OP_DIV   = 5'd23;
    localparam logic [4:0] OP_DIVU  = 5'd24;
    localparam logic [4:0] OP_MFHI  = 5'd25;
    localparam logic [4:0] OP_MFLO  = 5'd26;
    localparam logic [4:0] OP_MTHI  = 5'd27;
    localparam logic [4:0] OP_MTLO  = 5'd28;

    localparam int MSB = WIDTH - 1;
    localparam int IMW = (WIDTH < 16) ? WIDTH : 16;
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    // Issue register: every op is captured here first, giving the
    // one-edge latency for single-cycle ops and one setup edge for mult/div.
    logic             op_valid;
    logic [4:0]       op_code;
    logic [WIDTH-1:0] op_a, op_b;

    logic             is_mul, is_div, is_sgn, op_multi, start, accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] acc, q, m;
    logic             div_r, neg_q, neg_r, dz, fault;

    assign is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign is_div   = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign is_sgn   = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign op_multi = is_mul || is_div;

    assign start    = (state == IDLE) && op_valid && op_multi;
    assign in_ready = (state == IDLE) && !(op_valid && op_multi);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state != IDLE);

    assign a_neg = is_sgn && op_a[MSB];
    assign b_neg = is_sgn && op_b[MSB];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff, imm, sc_res;
    logic [SHW-1:0]   sh;
    logic             sc_ovf;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    assign sh   = op_a[SHW-1:0];

    always_comb begin
        imm = '0;
        imm[IMW-1:0] = op_b[IMW-1:0];
    end

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        unique case (op_code)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:  sc_res = op_a & op_b;
            OP_XOR:  sc_res = op_a ^ op_b;
            OP_OR:   sc_res = op_a | op_b;
            OP_NOR:  sc_res = ~(op_a | op_b);
            OP_ANDI: sc_res = op_a & imm;
            OP_XORI: sc_res = op_a ^ imm;
            OP_ORI:  sc_res = op_a | imm;
            OP_JR:   sc_res = op_a;
            OP_BEQ:  sc_res = WIDTH'(op_a == op_b);
            OP_BNE:  sc_res = WIDTH'(op_a != op_b);
            OP_BGEZ: sc_res = WIDTH'(!op_a[MSB]);
            OP_BGTZ: sc_res = WIDTH'(!op_a[MSB] && (op_a != '0));
            OP_BLEZ: sc_res = WIDTH'(op_a[MSB] || (op_a == '0));
            OP_BLTZ: sc_res = WIDTH'(op_a[MSB]);
            OP_SLL:  sc_res = op_b << sh;
            OP_SRL:  sc_res = op_b >> sh;
            OP_SRA:  sc_res = $signed(op_b) >>> sh;
            OP_SLT:  sc_res = WIDTH'($signed(op_a) < $signed(op_b));
            OP_SLTU: sc_res = WIDTH'(op_a < op_b);
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            OP_MTHI: sc_res = op_a;
            OP_MTLO: sc_res = op_a;
            default: sc_res = '0;
        endcase
    end

    // Iterative engine: acc holds the running high half / remainder,
    // q the multiplier being shifted out / dividend shifting into quotient.
    logic [WIDTH:0] madd, trial, tsub;

    assign madd  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign trial = {acc, q[MSB]};
    assign tsub  = trial - {1'b0, m};

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    assign prod     = {acc, q};
    assign prod_fix = neg_q ? -prod : prod;

    // Divide-by-zero leaves the dividend magnitude in acc, so restoring
    // its sign yields hi = a; MIN/-1 falls out naturally as lo = MIN.
    always_comb begin
        hi_fix = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix = prod_fix[WIDTH-1:0];
        if (div_r) begin
            hi_fix = neg_r ? -acc : acc;
            lo_fix = dz ? ONES : (neg_q ? -q : q);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (counter == CNT_W'(1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_code  <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                op_code <= alu_code;
                op_a    <= a;
                op_b    <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            div_r   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            fault   <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        counter <= CNT_W'(WIDTH);
                        acc     <= '0;
                        q       <= is_div ? a_mag : b_mag;
                        m       <= is_div ? b_mag : a_mag;
                        div_r   <= is_div;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        dz      <= is_div && (op_b == '0);
                        fault   <= is_div && ((op_b == '0) ||
                                   (is_sgn && op_a == MIN && op_b == ONES));
                    end
                end
                RUN: begin
                    counter <= counter - CNT_W'(1);
                    if (div_r) begin
                        if (!tsub[WIDTH]) begin
                            acc <= tsub[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= trial[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= madd[WIDTH:1];
                        q   <= {madd[0], q[MSB:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (!flush) begin
                if (state == FIX) begin
                    hi        <= hi_fix;
                    lo        <= lo_fix;
                    result    <= lo_fix;
                    overflow  <= fault;
                    out_valid <= 1'b1;
                end else if (op_valid && !op_multi) begin
                    result    <= sc_res;
                    overflow  <= sc_ovf;
                    out_valid <= 1'b1;
                    if (op_code == OP_MTHI) hi <= op_a;
                    if (op_code == OP_MTLO) lo <= op_a;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32 and 16).
// Ports driven: all inputs of two instances sharing clk/rst_n.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  alu_code = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow, busy;
    logic [31:0] result, hi, lo;

    logic        flush16 = 1'b0;
    logic        in_valid16 = 1'b0;
    logic [4:0]  code16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        in_ready16, out_valid16, overflow16, busy16;
    logic [15:0] result16, hi16, lo16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SHW(5), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_code(alu_code), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .overflow(overflow),
        .hi(hi), .lo(lo), .busy(busy)
    );

    alu_seq #(.WIDTH(16), .SHW(4), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush16),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_code(code16), .a(a16), .b(b16),
        .out_valid(out_valid16), .result(result16), .overflow(overflow16),
        .hi(hi16), .lo(lo16), .busy(busy16)
    );

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs [20] = '{
        '{5'd5,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0},
        '{5'd5,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
        '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
        '{5'd0,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1},
        '{5'd18, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0},
        '{5'd17, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0},
        '{5'd16, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 1'b0},
        '{5'd15, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0},
        '{5'd13, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{5'd14, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0},
        '{5'd12, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{5'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b0},
        '{5'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
        '{5'd19, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
        '{5'd20, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
        '{5'd6,  32'hFFFF_00FF, 32'hFFFF_0F0F, 32'h0000_000F, 1'b0},
        '{5'd8,  32'h1234_0000, 32'hFFFF_00AA, 32'h1234_00AA, 1'b0},
        '{5'd7,  32'h0000_FFFF, 32'hFFFF_FF00, 32'h0000_00FF, 1'b0},
        '{5'd4,  32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 1'b0},
        '{5'd29, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one accept edge, then wait for its result edge.
    task automatic single(input logic [4:0] code, input logic [31:0] x,
                          input logic [31:0] y);
        alu_code = code;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({in_ready, out_valid, busy, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctl got rdy/ov/busy/ovf=%b want 1000",
                     {in_ready, out_valid, busy, overflow});
        end
        checks++;
        if ({result, hi, lo} !== 96'h0) begin
            errors++;
            $display("FAIL reset_regs got res=%h hi=%h lo=%h want 0", result, hi, lo);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        alu_code = 5'd0;
        a = 32'h7FFF_FFFF;
        b = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_early got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, overflow, result} !== {1'b1, 1'b1, 32'h8000_0000}) begin
            errors++;
            $display("FAIL add_ovf got ov=%b ovf=%b res=%h want 1 1 80000000",
                     out_valid, overflow, result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pulse got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_table();
        for (int i = 0; i < 20; i++) begin
            single(vecs[i].code, vecs[i].x, vecs[i].y);
            checks++;
            if ({out_valid, overflow, result} !== {1'b1, vecs[i].ovf, vecs[i].res}) begin
                errors++;
                $display("FAIL vec%0d code=%0d got ov=%b ovf=%b res=%h want 1 %b %h",
                         i, vecs[i].code, out_valid, overflow, result,
                         vecs[i].ovf, vecs[i].res);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        logic [4:0]  ops [3];
        int bad;
        exp[0] = 32'h00F0_000F;
        exp[1] = 32'hFFF0_0FFF;
        exp[2] = 32'hFF00_0FF0;
        ops[0] = 5'd1;
        ops[1] = 5'd3;
        ops[2] = 5'd2;
        bad = 0;
        a = 32'hF0F0_00FF;
        b = 32'h0FF0_0F0F;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) alu_code = ops[i];
            else in_valid = 1'b0;
            tick();
            if (in_ready !== 1'b1) bad++;
            if (i > 0 && (out_valid !== 1'b1 || result !== exp[i-1])) bad++;
        end
        tick();
        if (out_valid !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic run_multi(input logic [4:0] code, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic eovf,
                             input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        alu_code = code;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (in_ready !== 1'b0) bad++;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                n = i;
                break;
            end
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        if (n != 0 && (in_ready !== 1'b1 || busy !== 1'b0)) bad++;
        checks++;
        if (n != 34) begin
            errors++;
            $display("FAIL %s_latency got %0d want 34", name, n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_handshake got %0d bad cycles want 0", name, bad);
        end
        checks++;
        if ({hi, lo, result, overflow} !== {ehi, elo, elo, eovf}) begin
            errors++;
            $display("FAIL %s got hi=%h lo=%h res=%h ovf=%b want %h %h %h %b",
                     name, hi, lo, result, overflow, ehi, elo, elo, eovf);
        end
    endtask

    task automatic test_muldiv();
        run_multi(5'd21, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult");
        single(5'd25, 32'h0, 32'h0);
        checks++;
        if (result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mfhi_after_mult got %h want ffffffff", result);
        end
        run_multi(5'd22, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, "multu");
        run_multi(5'd23, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div");
        run_multi(5'd24, 32'h0000_000A, 32'h0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, "divu_zero");
        run_multi(5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1, "div_min");
        single(5'd26, 32'h0, 32'h0);
        checks++;
        if (result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL mflo_after_div got %h want 80000000", result);
        end
    endtask

    task automatic test_hilo_move();
        alu_code = 5'd27;
        a = 32'h1234_5678;
        in_valid = 1'b1;
        tick();
        alu_code = 5'd25;
        a = 32'h0;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, hi} !== {1'b1, 32'h1234_5678, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mthi got ov=%b res=%h hi=%h want 1 12345678 12345678",
                     out_valid, result, hi);
        end
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mfhi_b2b got ov=%b res=%h want 1 12345678", out_valid, result);
        end
        single(5'd27, 32'h0000_1111, 32'h0);
        single(5'd28, 32'h0000_2222, 32'h0);
        checks++;
        if ({hi, lo, result} !== {32'h1111, 32'h2222, 32'h2222}) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h res=%h want 1111 2222 2222", hi, lo, result);
        end
    endtask

    task automatic test_flush();
        int seen;
        alu_code = 5'd23;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL flush_ctl got busy/rdy/ov=%b want 010", {busy, in_ready, out_valid});
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || hi !== 32'h1111 || lo !== 32'h2222) begin
            errors++;
            $display("FAIL flush_hold got pulses=%0d hi=%h lo=%h want 0 1111 2222", seen, hi, lo);
        end
        flush = 1'b1;
        alu_code = 5'd0;
        a = 32'd1;
        b = 32'd1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard got ov=%b want 0", out_valid);
        end
        single(5'd26, 32'h0, 32'h0);
        checks++;
        if ({out_valid, result} !== {1'b1, 32'h2222}) begin
            errors++;
            $display("FAIL flush_mflo got ov=%b res=%h want 1 2222", out_valid, result);
        end
    endtask

    task automatic test_reset_mid();
        alu_code = 5'd21;
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hi, lo, result} !== 96'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got hi=%h lo=%h res=%h rdy=%b busy=%b want 0 0 0 1 0",
                     hi, lo, result, in_ready, busy);
        end
        #2 rst_n = 1'b1;
        tick();
        single(5'd0, 32'd2, 32'd3);
        checks++;
        if ({out_valid, result} !== {1'b1, 32'd5}) begin
            errors++;
            $display("FAIL after_reset_add got ov=%b res=%h want 1 5", out_valid, result);
        end
    endtask

    task automatic run16(input logic [4:0] code, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] ehi,
                         input logic [15:0] elo, input string name);
        int n;
        n = 0;
        code16 = code;
        a16 = x;
        b16 = y;
        in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (out_valid16 === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL %s_latency got %0d want 18", name, n);
        end
        checks++;
        if ({hi16, lo16, result16} !== {ehi, elo, elo}) begin
            errors++;
            $display("FAIL %s got hi=%h lo=%h res=%h want %h %h %h",
                     name, hi16, lo16, result16, ehi, elo, elo);
        end
    endtask

    task automatic test_width16();
        run16(5'd21, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, "w16_mult");
        run16(5'd22, 16'hFFFE, 16'h0003, 16'h0002, 16'hFFFA, "w16_multu");
        run16(5'd22, 16'h1234, 16'h0100, 16'h0012, 16'h3400, "w16_multu2");
    endtask

    initial begin
        test_reset();
        test_add();
        test_table();
        test_back_to_back();
        test_muldiv();
        test_hilo_move();
        test_flush();
        test_reset_mid();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
